// File: rtl/microwave_pkg.sv
// ---------------------------------------------------------------------------
// microwave_pkg : mode encodings, add-time constants and a saturating adder
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package microwave_pkg;

  localparam int TIME_W = 13;

  // Shared with the DC motor controller; the encodings must not change.
  typedef enum logic [2:0] {
    MODE_IDLE   = 3'b000,
    MODE_SET    = 3'b001,
    MODE_RUN    = 3'b010,
    MODE_STOP   = 3'b011,
    MODE_FINISH = 3'b100
  } mode_e;

  localparam int ADD_SHORT = 10;
  localparam int ADD_LONG  = 60;
  localparam int QUICK_SEC = 30;

  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] a,
                                                input logic [TIME_W-1:0] n,
                                                input logic [TIME_W-1:0] lim);
    logic [TIME_W:0] s;
    s = {1'b0, a} + {1'b0, n};
    if (s > {1'b0, lim}) return lim;
    return s[TIME_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/microwave_cook_fsm_if.sv
// ---------------------------------------------------------------------------
// microwave_cook_fsm_if : button/door inputs and mode/display/buzzer outputs
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface microwave_cook_fsm_if;

  logic       btn_start;
  logic       btn_stop;
  logic       btn_add_10s;
  logic       btn_add_1m;
  logic       door_open;
  logic [2:0] mode;
  logic [6:0] remain_min;
  logic [5:0] remain_sec;
  logic       buzzer;
  logic       done;

  modport master (
    output btn_start, btn_stop, btn_add_10s, btn_add_1m, door_open,
    input  mode, remain_min, remain_sec, buzzer, done
  );

  modport slave (
    input  btn_start, btn_stop, btn_add_10s, btn_add_1m, door_open,
    output mode, remain_min, remain_sec, buzzer, done
  );

endinterface

`default_nettype wire

// File: rtl/microwave_cook_fsm_sec_tick_gen.sv
// ---------------------------------------------------------------------------
// sec_tick_gen : prescaler producing a one-cycle tick every CLK_HZ cycles
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && !clear && (cnt_q == TERM);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/microwave_cook_fsm.sv
// ---------------------------------------------------------------------------
// microwave_cook_fsm : cook-time entry, 1 s countdown, finish buzzer/done.
// Optional: MICROWAVE_QUICK_START_EN (start in IDLE loads 30 s and runs;
//           start in RUN adds 30 s).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module microwave_cook_fsm
  import microwave_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int MAX_SEC  = 5999,
  parameter int BEEP_SEC = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  microwave_cook_fsm_if.slave  bus
);

  localparam int               BEEP_W = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SEC - 1);
  localparam logic [TIME_W-1:0] MAX_T   = TIME_W'(MAX_SEC);
  localparam logic [TIME_W-1:0] T_SHORT = TIME_W'(ADD_SHORT);
  localparam logic [TIME_W-1:0] T_LONG  = TIME_W'(ADD_LONG);
  localparam logic [TIME_W-1:0] T_QUICK = TIME_W'(QUICK_SEC);

  mode_e             mode_q, mode_d;
  logic [TIME_W-1:0] t_q, t_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic              buzzer_q, buzzer_d;
  logic              done_q, done_d;

  logic              w_tick;
  logic              w_tick_en;
  logic              w_tick_clr;
  logic              w_add;
  logic [TIME_W-1:0] w_add_n;
  logic              w_any_evt;
  logic [TIME_W-1:0] w_base;

  // The prescaler is shared: it times the RUN countdown and the FINISH beep.
  assign w_tick_en  = ((mode_q == MODE_RUN) && (t_q != '0)) || (mode_q == MODE_FINISH);
  assign w_tick_clr = (mode_q != MODE_RUN) && (mode_q != MODE_FINISH);

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (w_tick_en),
    .clear   (w_tick_clr),
    .tick    (w_tick)
  );

  assign w_add     = bus.btn_add_1m || bus.btn_add_10s;
  assign w_add_n   = bus.btn_add_1m ? T_LONG : T_SHORT;
  assign w_any_evt = bus.door_open || bus.btn_start || bus.btn_stop || w_add;

  always_comb begin
    mode_d   = mode_q;
    t_d      = t_q;
    beep_d   = beep_q;
    buzzer_d = buzzer_q;
    done_d   = 1'b0;
    w_base   = t_q - (w_tick ? TIME_W'(1) : TIME_W'(0));

    unique case (mode_q)
      MODE_IDLE: begin
        if (bus.btn_stop) begin
          t_d = '0;
        end else if (bus.btn_start) begin
`ifdef MICROWAVE_QUICK_START_EN
          if (!bus.door_open && (t_q == '0)) begin
            t_d    = T_QUICK;
            mode_d = MODE_RUN;
          end
`endif
        end else if (w_add) begin
          t_d    = sat_add(t_q, w_add_n, MAX_T);
          mode_d = MODE_SET;
        end
      end

      MODE_SET: begin
        if (bus.btn_stop) begin
          t_d    = '0;
          mode_d = MODE_IDLE;
        end else if (bus.btn_start) begin
          if (!bus.door_open && (t_q != '0)) mode_d = MODE_RUN;
        end else if (w_add) begin
          t_d = sat_add(t_q, w_add_n, MAX_T);
        end
      end

      MODE_RUN: begin
        // Pausing takes precedence over a coincident tick: time is held.
        if (bus.door_open || bus.btn_stop) begin
          mode_d = MODE_STOP;
        end else begin
          t_d = w_base;
          if (bus.btn_start) begin
`ifdef MICROWAVE_QUICK_START_EN
            t_d = sat_add(w_base, T_QUICK, MAX_T);
`endif
          end else if (bus.btn_add_1m) begin
            t_d = sat_add(w_base, T_LONG, MAX_T);
          end
          if (t_d == '0) begin
            mode_d   = MODE_FINISH;
            done_d   = 1'b1;
            buzzer_d = 1'b1;
            beep_d   = '0;
          end
        end
      end

      MODE_STOP: begin
        if (bus.btn_stop) begin
          t_d    = '0;
          mode_d = MODE_IDLE;
        end else if (bus.btn_start) begin
          if (!bus.door_open && (t_q != '0)) mode_d = MODE_RUN;
        end else if (w_add) begin
          t_d = sat_add(t_q, w_add_n, MAX_T);
        end
      end

      MODE_FINISH: begin
        if (w_any_evt) begin
          mode_d   = MODE_IDLE;
          buzzer_d = 1'b0;
          beep_d   = '0;
        end else if (w_tick) begin
          if (beep_q == BEEP_LAST) begin
            mode_d   = MODE_IDLE;
            buzzer_d = 1'b0;
            beep_d   = '0;
          end else begin
            beep_d = beep_q + BEEP_W'(1);
          end
        end
      end

      default: begin
        mode_d   = MODE_IDLE;
        t_d      = '0;
        beep_d   = '0;
        buzzer_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q   <= MODE_IDLE;
      t_q      <= '0;
      beep_q   <= '0;
      buzzer_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      t_q      <= t_d;
      beep_q   <= beep_d;
      buzzer_q <= buzzer_d;
      done_q   <= done_d;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.remain_min = 7'(t_q / TIME_W'(60));
  assign bus.remain_sec = 6'(t_q % TIME_W'(60));
  assign bus.buzzer     = buzzer_q;
  assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_microwave_cook_fsm.sv
// ---------------------------------------------------------------------------
// tb_microwave_cook_fsm : directed stimulus with a queued-expectation monitor
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_microwave_cook_fsm;
    import microwave_pkg::*;

    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_ADD10 = 2;
    localparam int B_ADD1M = 3;

    typedef struct {
        string      name;
        logic [2:0] mode;
        logic [6:0] min;
        logic [5:0] sec;
        logic       buz;
        logic       done;
    } exp_t;

    logic clk;
    logic reset_n;
    microwave_cook_fsm_if bus();

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    microwave_cook_fsm #(
        .CLK_HZ   (10),
        .MAX_SEC  (5999),
        .BEEP_SEC (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int b);
        case (b)
            B_START: bus.btn_start   = 1'b1;
            B_STOP:  bus.btn_stop    = 1'b1;
            B_ADD10: bus.btn_add_10s = 1'b1;
            default: bus.btn_add_1m  = 1'b1;
        endcase
        step(1);
        bus.btn_start   = 1'b0;
        bus.btn_stop    = 1'b0;
        bus.btn_add_10s = 1'b0;
        bus.btn_add_1m  = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [2:0] mode,
                              input int min, input int sec,
                              input logic buz, input logic done);
        exp_t e;
        e.name = name;
        e.mode = mode;
        e.min  = 7'(min);
        e.sec  = 6'(sec);
        e.buz  = buz;
        e.done = done;
        exp_q.push_back(e);
    endtask

    // Monitor: drains pending expectations against the outputs mid-cycle.
    initial begin
        exp_t e;
        n_checks = 0;
        n_fail   = 0;
        forever begin
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.mode, bus.remain_min, bus.remain_sec, bus.buzzer, bus.done} !==
                    {e.mode, e.min, e.sec, e.buz, e.done}) begin
                    n_fail++;
                    $display("FAIL %s: got mode=%0d %0d:%0d buzzer=%0b done=%0b, expected mode=%0d %0d:%0d buzzer=%0b done=%0b",
                             e.name, bus.mode, bus.remain_min, bus.remain_sec, bus.buzzer, bus.done,
                             e.mode, e.min, e.sec, e.buz, e.done);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        bus.btn_start   = 1'b0;
        bus.btn_stop    = 1'b0;
        bus.btn_add_10s = 1'b0;
        bus.btn_add_1m  = 1'b0;
        bus.door_open   = 1'b0;
        step(2);
        expect_out("reset", MODE_IDLE, 0, 0, 1'b0, 1'b0);
        n_checks++;
        if (bus.mode !== MODE_IDLE) begin
            n_fail++;
            $display("FAIL reset_mode_direct: got mode=%0d, expected mode=%0d", bus.mode, MODE_IDLE);
        end
        reset_n = 1'b1;
        step(1);

        // Reset in the middle of a cook at 0:45
        repeat (5) press(B_ADD10);
        expect_out("set_0_50", MODE_SET, 0, 50, 1'b0, 1'b0);
        press(B_START);
        step(50);
        expect_out("run_0_45", MODE_RUN, 0, 45, 1'b0, 1'b0);
        reset_n = 1'b0;
        step(1);
        expect_out("reset_mid_run", MODE_IDLE, 0, 0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step(1);
        expect_out("after_reset_idle", MODE_IDLE, 0, 0, 1'b0, 1'b0);

        // Full cook of 1:10 through the finish beep
        press(B_ADD1M);
        expect_out("add_1m_set", MODE_SET, 1, 0, 1'b0, 1'b0);
        press(B_ADD10);
        expect_out("add_10s_set", MODE_SET, 1, 10, 1'b0, 1'b0);
        press(B_START);
        expect_out("start_run", MODE_RUN, 1, 10, 1'b0, 1'b0);
        step(9);
        expect_out("no_tick_yet", MODE_RUN, 1, 10, 1'b0, 1'b0);
        step(1);
        expect_out("first_tick", MODE_RUN, 1, 9, 1'b0, 1'b0);
        step(689);
        expect_out("last_second", MODE_RUN, 0, 1, 1'b0, 1'b0);
        step(1);
        expect_out("finish_entry", MODE_FINISH, 0, 0, 1'b1, 1'b1);
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL finish_done_direct: got done=%0b, expected done=1", bus.done);
        end
        step(1);
        expect_out("done_one_cycle", MODE_FINISH, 0, 0, 1'b1, 1'b0);
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_direct: got done=%0b, expected done=0", bus.done);
        end
        step(28);
        expect_out("beep_window_end", MODE_FINISH, 0, 0, 1'b1, 1'b0);
        step(1);
        expect_out("beep_to_idle", MODE_IDLE, 0, 0, 1'b0, 1'b0);
        n_checks++;
        if (bus.buzzer !== 1'b0) begin
            n_fail++;
            $display("FAIL buzzer_off_direct: got buzzer=%0b, expected buzzer=0", bus.buzzer);
        end

        // Door open pauses; start ignored with door open; resume gives a full second
        press(B_ADD10);
        press(B_ADD10);
        expect_out("set_0_20", MODE_SET, 0, 20, 1'b0, 1'b0);
        press(B_START);
        bus.door_open = 1'b1;
        step(1);
        expect_out("door_stop", MODE_STOP, 0, 20, 1'b0, 1'b0);
        press(B_START);
        expect_out("start_door_open", MODE_STOP, 0, 20, 1'b0, 1'b0);
        bus.door_open = 1'b0;
        step(1);
        press(B_START);
        expect_out("resume_run", MODE_RUN, 0, 20, 1'b0, 1'b0);
        step(9);
        expect_out("resume_no_tick", MODE_RUN, 0, 20, 1'b0, 1'b0);
        step(1);
        expect_out("resume_tick", MODE_RUN, 0, 19, 1'b0, 1'b0);

        // Stop coincident with a tick: stop wins, no decrement
        step(9);
        bus.btn_stop = 1'b1;
        step(1);
        bus.btn_stop = 1'b0;
        expect_out("stop_beats_tick", MODE_STOP, 0, 19, 1'b0, 1'b0);
        press(B_STOP);
        expect_out("stop_cancel", MODE_IDLE, 0, 0, 1'b0, 1'b0);

        // add_1m coincident with a tick nets +59; add_10s ignored in RUN
        press(B_ADD10);
        press(B_START);
        step(9);
        bus.btn_add_1m = 1'b1;
        step(1);
        bus.btn_add_1m = 1'b0;
        expect_out("tick_plus_1m", MODE_RUN, 1, 9, 1'b0, 1'b0);
        press(B_ADD10);
        expect_out("run_add10_ignored", MODE_RUN, 1, 9, 1'b0, 1'b0);
        press(B_STOP);
        press(B_STOP);
        expect_out("cancel_again", MODE_IDLE, 0, 0, 1'b0, 1'b0);

        // Saturation at 99:59
        repeat (99) press(B_ADD1M);
        repeat (5) press(B_ADD10);
        expect_out("set_99_50", MODE_SET, 99, 50, 1'b0, 1'b0);
        press(B_ADD1M);
        expect_out("sat_add_1m", MODE_SET, 99, 59, 1'b0, 1'b0);
        press(B_ADD10);
        expect_out("sat_add_10s", MODE_SET, 99, 59, 1'b0, 1'b0);
        n_checks++;
        if ({bus.remain_min, bus.remain_sec} !== {7'd99, 6'd59}) begin
            n_fail++;
            $display("FAIL sat_direct: got %0d:%0d, expected 99:59", bus.remain_min, bus.remain_sec);
        end
        press(B_STOP);
        expect_out("sat_cancel", MODE_IDLE, 0, 0, 1'b0, 1'b0);

        // Start from IDLE with no time loaded
        press(B_START);
`ifdef MICROWAVE_QUICK_START_EN
        expect_out("quick_start", MODE_RUN, 0, 30, 1'b0, 1'b0);
`else
        expect_out("idle_start_ignored", MODE_IDLE, 0, 0, 1'b0, 1'b0);
`endif

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
